// File: rtl/nibble_cmp_chain.sv
// ---------------------------------------------------------------------------
// nibble_cmp_chain
//
// Purpose:
//   Sits directly after the 4-bit magnitude comparator and folds its
//   per-nibble lt/eq/gt results into one unsigned compare of a
//   NIBBLES*4-bit word. Nibbles are requested MSB first through nib_idx,
//   which drives the operand mux in front of the comparator. The first
//   unequal nibble decides the word result; later nibbles cannot change it.
//
// Optional feature:
//   NIBBLE_CMP_EARLY_EXIT_EN - when defined, the first deciding beat ends
//   the compare immediately and nib_idx holds its value. When undefined,
//   every nibble is always consumed, so latency does not depend on data.
//   The final result is the same in both builds.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset, aborts a compare in flight
//   start     in   begin a compare (honoured in IDLE or DONE only)
//   in_valid  in   comparator result for nibble nib_idx is present
//   lt_in     in   comparator a < b for the current nibble
//   eq_in     in   comparator a == b for the current nibble
//   gt_in     in   comparator a > b for the current nibble
//   in_ready  out  block accepts a nibble result this cycle
//   nib_idx   out  index of the requested nibble, NIBBLES-1 down to 0
//   busy      out  compare in progress
//   done      out  one-cycle pulse when the result is final
//   res_lt    out  word a < b, held until the next start
//   res_eq    out  word a == b, held until the next start
//   res_gt    out  word a > b, held until the next start
//   err       out  sticky, a malformed nibble result was accepted
// ---------------------------------------------------------------------------
module nibble_cmp_chain #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic                       lt_in,
  input  logic                       eq_in,
  input  logic                       gt_in,
  output logic                       in_ready,
  output logic [$clog2(NIBBLES)-1:0] nib_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       res_lt,
  output logic                       res_eq,
  output logic                       res_gt,
  output logic                       err
);

  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  // Which way the word has been decided; both clear means still equal.
  logic dec_lt;
  logic dec_gt;

  logic decided;
  logic beat;
  logic one_hot;
  logic take_lt;
  logic take_gt;
  logic fin_lt;
  logic fin_gt;
  logic finish;

  // Beat qualification and the result as it would stand after this beat.
  // A malformed beat is treated as eq, so it can never decide the word.
  always_comb begin
    decided = dec_lt | dec_gt;
    beat    = in_valid & in_ready;
    one_hot = ( lt_in & ~eq_in & ~gt_in) |
              (~lt_in &  eq_in & ~gt_in) |
              (~lt_in & ~eq_in &  gt_in);
    take_lt = beat & one_hot & ~decided & lt_in;
    take_gt = beat & one_hot & ~decided & gt_in;
    fin_lt  = dec_lt | take_lt;
    fin_gt  = dec_gt | take_gt;
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
    finish  = (beat & (nib_idx == '0)) | take_lt | take_gt;
`else
    finish  = beat & (nib_idx == '0);
`endif
  end

  // Control FSM. All outputs are registered; in_ready and busy mirror RUN.
  // IDLE and DONE share the start path so a start held through DONE
  // launches the next compare with no IDLE cycle in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nib_idx  <= LAST_IDX;
      res_lt   <= 1'b0;
      res_eq   <= 1'b0;
      res_gt   <= 1'b0;
      err      <= 1'b0;
      dec_lt   <= 1'b0;
      dec_gt   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            nib_idx  <= LAST_IDX;
            dec_lt   <= 1'b0;
            dec_gt   <= 1'b0;
            err      <= 1'b0;
            res_lt   <= 1'b0;
            res_eq   <= 1'b0;
            res_gt   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (beat) begin
            if (!one_hot) begin
              err <= 1'b1;
            end
            if (take_lt) begin
              dec_lt <= 1'b1;
            end
            if (take_gt) begin
              dec_gt <= 1'b1;
            end
            // On an early exit nib_idx is left where it was.
            if (finish) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              res_lt   <= fin_lt;
              res_gt   <= fin_gt;
              res_eq   <= ~(fin_lt | fin_gt);
            end else begin
              nib_idx <= nib_idx - IDXW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_cmp_chain.sv
// ---------------------------------------------------------------------------
// tb_nibble_cmp_chain
//
// Directed bench for nibble_cmp_chain with NIBBLES=4. The bench plays the
// role of the 4-bit comparator: it slices its own operands by the nibble
// index it expects to be requested. Each issued compare pushes its
// hand-computed result and done edge into a queue; a monitor pops and
// compares whenever done is seen. Latency expectations follow
// NIBBLE_CMP_EARLY_EXIT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_nibble_cmp_chain;

  localparam int NIBBLES = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       lt_in;
  logic       eq_in;
  logic       gt_in;
  logic       in_ready;
  logic [1:0] nib_idx;
  logic       busy;
  logic       done;
  logic       res_lt;
  logic       res_eq;
  logic       res_gt;
  logic       err;

  typedef struct {
    logic lt;
    logic eq;
    logic gt;
    logic err;
    int   doneEdge;
  } exp_t;

  exp_t expQ[$];
  int   edgeCnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  nibble_cmp_chain #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .lt_in    (lt_in),
    .eq_in    (eq_in),
    .gt_in    (gt_in),
    .in_ready (in_ready),
    .nib_idx  (nib_idx),
    .busy     (busy),
    .done     (done),
    .res_lt   (res_lt),
    .res_eq   (res_eq),
    .res_gt   (res_gt),
    .err      (err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to time done against the start edge
  always @(posedge clk) begin
    edgeCnt <= edgeCnt + 1;
  end

  // Hard stop in case the design never finishes a compare
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("res_lt", int'(res_lt), int'(e.lt));
        checkOutput("res_eq", int'(res_eq), int'(e.eq));
        checkOutput("res_gt", int'(res_gt), int'(e.gt));
        checkOutput("err", int'(err), int'(e.err));
        checkOutput("done_edge", edgeCnt, e.doneEdge);
      end
    end
  end

  // Queue the expected result for a start that the next rising edge samples
  task automatic pushExp(input logic eLt, input logic eEq, input logic eGt,
                         input logic eErr, input int lat);
    exp_t e;
    e.lt       = eLt;
    e.eq       = eEq;
    e.gt       = eGt;
    e.err      = eErr;
    e.doneEdge = edgeCnt + 1 + lat;
    expQ.push_back(e);
  endtask

  // Feed comparator results MSB first; stall cycles precede every beat.
  // badIdx selects a nibble to send as lt=gt=1 (-1 for none).
  task automatic sendBeats(input logic [15:0] a, input logic [15:0] b,
                           input int stall, input int badIdx);
    logic [3:0] an;
    logic [3:0] bn;
    for (int k = NIBBLES - 1; k >= 0; k--) begin
      if (!busy) break;
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b0;
        checkOutput("idx_stall", int'(nib_idx), k);
        @(negedge clk);
      end
      checkOutput("idx_beat", int'(nib_idx), k);
      an = a[k*4 +: 4];
      bn = b[k*4 +: 4];
      lt_in = (an < bn);
      eq_in = (an == bn);
      gt_in = (an > bn);
      if (k == badIdx) begin
        lt_in = 1'b1;
        eq_in = 1'b0;
        gt_in = 1'b1;
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lt_in    = 1'b0;
      eq_in    = 1'b0;
      gt_in    = 1'b0;
    end
  endtask

  // One complete compare starting and ending on a falling edge
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int stall, input int badIdx,
                               input logic eLt, input logic eEq, input logic eGt,
                               input logic eErr, input int lat);
    start = 1'b1;
    pushExp(eLt, eEq, eGt, eErr, lat);
    @(negedge clk);
    start = 1'b0;
    checkOutput("run_busy", int'(busy), 1);
    checkOutput("run_ready", int'(in_ready), 1);
    checkOutput("run_err_clear", int'(err), 0);
    checkOutput("run_res_clear", int'({res_lt, res_eq, res_gt}), 0);
    sendBeats(a, b, stall, badIdx);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int latGt;
    int latRevLt;
    int latMidLt;
    int idxAfterGt;
`ifdef NIBBLE_CMP_EARLY_EXIT_EN
    latGt      = 1;
    latRevLt   = 1;
    latMidLt   = 3;
    idxAfterGt = 3;
`else
    latGt      = 4;
    latRevLt   = 4;
    latMidLt   = 4;
    idxAfterGt = 0;
`endif
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    lt_in    = 1'b0;
    eq_in    = 1'b0;
    gt_in    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", int'(in_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_idx", int'(nib_idx), 3);
    checkOutput("rst_res", int'({res_lt, res_eq, res_gt}), 0);
    checkOutput("rst_err", int'(err), 0);

    $display("[TB] equal words");
    applyStimulus(16'h1234, 16'h1234, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    checkOutput("idx_after_eq", int'(nib_idx), 0);

    $display("[TB] greater on first nibble");
    applyStimulus(16'h8000, 16'h7FFF, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, latGt);
    checkOutput("idx_after_gt", int'(nib_idx), idxAfterGt);

    $display("[TB] less on last nibble with stalls");
    applyStimulus(16'h1233, 16'h1234, 2, -1, 1'b1, 1'b0, 1'b0, 1'b0, 12);

    $display("[TB] later nibbles cannot override the decision");
    applyStimulus(16'h19FF, 16'h2000, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, latRevLt);

    $display("[TB] less on a middle nibble");
    applyStimulus(16'h00A0, 16'h00B0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, latMidLt);

    $display("[TB] malformed beat at nibble 2");
    applyStimulus(16'h5555, 16'h5555, 0, 2, 1'b0, 1'b1, 1'b0, 1'b1, 4);
    checkOutput("err_held", int'(err), 1);

    $display("[TB] reset on second beat");
    start = 1'b1;
    pushExp(1'b0, 1'b1, 1'b0, 1'b0, 4);
    @(negedge clk);
    start    = 1'b0;
    eq_in    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    eq_in    = 1'b0;
    void'(expQ.pop_back());
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_ready", int'(in_ready), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_res", int'({res_lt, res_eq, res_gt}), 0);
    checkOutput("abort_err", int'(err), 0);
    checkOutput("abort_idx", int'(nib_idx), 3);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", int'(done), 0);
    end

    $display("[TB] compare after abort");
    applyStimulus(16'hABCD, 16'hABCC, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 4);

    $display("[TB] back-to-back compares with start held");
    start = 1'b1;
    pushExp(1'b0, 1'b0, 1'b1, 1'b0, latGt);
    @(negedge clk);
    sendBeats(16'h8000, 16'h7FFF, 0, -1);
    checkOutput("b2b_done", int'(done), 1);
    pushExp(1'b1, 1'b0, 1'b0, 1'b0, 4);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy", int'(busy), 1);
    checkOutput("b2b_res_clear", int'({res_lt, res_eq, res_gt}), 0);
    sendBeats(16'h1234, 16'h1235, 0, -1);
    @(negedge clk);
    checkOutput("b2b_idle", int'(busy), 0);
    checkOutput("b2b_res_lt_held", int'(res_lt), 1);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
